// File: rtl/dds_multiwave.sv
// dds_multiwave: phase-accumulator DDS with saw/triangle/square/sine outputs.
// Define DDS_DITHER_EN to add LFSR dither ahead of phase truncation.
module dds_multiwave #(
  parameter int ACC_W   = 32,
  parameter int PHASE_W = 11,
  parameter int OUT_W   = 10,
  parameter int ROM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               sync_clr,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [ACC_W-1:0]   cfg_freq,
  input  logic [PHASE_W-1:0] cfg_phase,
  input  logic [1:0]         cfg_mode,
  input  logic [PHASE_W-1:0] cfg_duty,
  output logic [PHASE_W-1:0] rom_addr,
  input  logic [OUT_W-1:0]   rom_data,
  output logic [OUT_W-1:0]   wave_out,
  output logic               wave_valid,
  output logic               wrap
);

  localparam int VL = 2 + ROM_LAT;

  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   act_freq;
  logic [ACC_W-1:0]   sh_freq;
  logic [PHASE_W-1:0] act_phase;
  logic [PHASE_W-1:0] sh_phase;
  logic [PHASE_W-1:0] act_duty;
  logic [PHASE_W-1:0] sh_duty;
  logic [1:0]         act_mode;
  logic [1:0]         sh_mode;
  logic               pending;
  logic [ACC_W:0]     sum;
  logic               carry;
  logic               xfer;
  logic               apply;

  assign sum   = {1'b0, acc} + {1'b0, act_freq};
  assign carry = enable && !sync_clr && sum[ACC_W];
  assign xfer  = cfg_valid && !pending;
  // shadow only lands on a wrap, an idle cycle or a clear
  assign apply = pending && (sync_clr || !enable || carry);
  assign cfg_ready = !pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      wrap      <= 1'b0;
      pending   <= 1'b0;
      act_freq  <= '0;
      act_phase <= '0;
      act_duty  <= '0;
      act_mode  <= 2'b00;
      sh_freq   <= '0;
      sh_phase  <= '0;
      sh_duty   <= '0;
      sh_mode   <= 2'b00;
    end else begin
      if (sync_clr)
        acc <= '0;
      else if (enable)
        acc <= sum[ACC_W-1:0];
      wrap <= carry;
      if (apply) begin
        act_freq  <= sh_freq;
        act_phase <= sh_phase;
        act_duty  <= sh_duty;
        act_mode  <= sh_mode;
      end
      if (xfer) begin
        sh_freq  <= cfg_freq;
        sh_phase <= cfg_phase;
        sh_duty  <= cfg_duty;
        sh_mode  <= cfg_mode;
      end
      pending <= xfer | (pending & ~apply);
    end
  end

  logic [PHASE_W-1:0] acc_hi;

`ifdef DDS_DITHER_EN
  localparam int TW = ACC_W - PHASE_W;
  localparam int DW = (TW < 16) ? TW : 16;
  logic [15:0]      lfsr;
  logic [ACC_W-1:0] acc_dith;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lfsr <= 16'hACE1;
    else if (enable)
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign acc_dith = acc + ACC_W'(lfsr[DW-1:0]);
  assign acc_hi   = acc_dith[ACC_W-1 -: PHASE_W];
`else
  assign acc_hi = acc[ACC_W-1 -: PHASE_W];
`endif

  logic [PHASE_W-1:0] phase_r;
  logic [PHASE_W-1:0] duty_r;
  logic [1:0]         mode_r;

  // mode and duty travel with the phase so a switch never mixes samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_r <= '0;
      duty_r  <= '0;
      mode_r  <= 2'b00;
    end else begin
      phase_r <= acc_hi + act_phase;
      duty_r  <= act_duty;
      mode_r  <= act_mode;
    end
  end

  assign rom_addr = phase_r;

  logic [OUT_W-1:0] tri_t;
  logic [OUT_W-1:0] samp;
  logic             is_saw;
  logic             is_tri;
  logic             is_sqr;

  assign tri_t  = phase_r[PHASE_W-2 -: OUT_W];
  assign is_saw = (mode_r == 2'b00);
  assign is_tri = (mode_r == 2'b01);
  assign is_sqr = (mode_r == 2'b10);

  always_comb begin
    samp = '0;
    unique case (1'b1)
      is_saw:  samp = phase_r[PHASE_W-1 -: OUT_W];
      is_tri:  samp = phase_r[PHASE_W-1] ? ~tri_t : tri_t;
      is_sqr:  samp = {OUT_W{phase_r < duty_r}};
      default: samp = '0;
    endcase
  end

  logic [ROM_LAT-1:0][OUT_W-1:0] samp_d;
  logic [ROM_LAT-1:0]            sine_d;
  logic [VL-1:0]                 vld;

  // non-sine samples wait out the ROM latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_d   <= '0;
      sine_d   <= '0;
      vld      <= '0;
      wave_out <= '0;
    end else begin
      samp_d[0] <= samp;
      sine_d[0] <= (mode_r == 2'b11);
      for (int i = 1; i < ROM_LAT; i++) begin
        samp_d[i] <= samp_d[i-1];
        sine_d[i] <= sine_d[i-1];
      end
      vld <= {vld[VL-2:0], enable};
      if (vld[VL-2])
        wave_out <= sine_d[ROM_LAT-1] ? rom_data : samp_d[ROM_LAT-1];
    end
  end

  assign wave_valid = vld[VL-1];

endmodule
